// File: rtl/e203_itcm_loader.sv
// Boot-image loader: packs a little-endian byte stream into 64-bit ITCM lines and writes them
// over a single-outstanding ICB port, holding the core in reset until the image is complete.
module e203_itcm_loader #(
  parameter int             AW        = 16,
  parameter logic [AW-1:0]  BASE_ADDR = 16'h0000,
  parameter int             MAX_WORDS = 8192,
  parameter int             CW        = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [CW-1:0] load_len,
  input  logic          load_abort,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          icb_cmd_valid,
  input  logic          icb_cmd_ready,
  output logic [AW-1:0] icb_cmd_addr,
  output logic          icb_cmd_read,
  output logic [63:0]   icb_cmd_wdata,
  output logic [7:0]    icb_cmd_wmask,
  input  logic          icb_rsp_valid,
  output logic          icb_rsp_ready,
  input  logic          icb_rsp_err,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [CW-1:0] words_written
);

  typedef enum logic [2:0] {IDLE, COLLECT, CMD, RSP, DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic [2:0]    byte_idx;
  logic [CW-1:0] word_idx;
  logic [CW-1:0] len_q;
  logic          abort_q;
  logic          start_ok, take_byte, rsp_ok;
  logic          len_zero, len_big, last_word;

  assign icb_cmd_read  = 1'b0;
  assign icb_cmd_wmask = 8'hFF;
  assign icb_rsp_ready = 1'b1;

  assign len_zero  = (load_len == '0);
  assign len_big   = (32'(load_len) > MAX_WORDS);
  assign last_word = ((word_idx + CW'(1)) == len_q);

  assign core_hold = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    byte_ready    = 1'b0;
    icb_cmd_valid = 1'b0;
    start_ok      = 1'b0;
    take_byte     = 1'b0;
    rsp_ok        = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (load_start) begin
          if (len_zero)     state_nxt = DONE;
          else if (len_big) state_nxt = ERR;
          else begin
            start_ok  = 1'b1;
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        // An abort wins over a byte offered in the same cycle, so no byte is taken.
        if (load_abort) state_nxt = ERR;
        else begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            take_byte = 1'b1;
            if (byte_idx == 3'd7) state_nxt = CMD;
          end
        end
      end
      CMD: begin
        icb_cmd_valid = 1'b1;
        if (icb_cmd_ready)   state_nxt = RSP;
        else if (load_abort) state_nxt = ERR;
      end
      RSP: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) state_nxt = ERR;
          else begin
            rsp_ok = 1'b1;
            if (abort_q || load_abort) state_nxt = ERR;
            else if (last_word)        state_nxt = DONE;
            else                       state_nxt = COLLECT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx      <= '0;
      word_idx      <= '0;
      len_q         <= '0;
      abort_q       <= 1'b0;
      icb_cmd_addr  <= '0;
      icb_cmd_wdata <= '0;
      words_written <= '0;
    end else begin
      if (start_ok) begin
        byte_idx      <= '0;
        word_idx      <= '0;
        len_q         <= load_len;
        abort_q       <= 1'b0;
        icb_cmd_wdata <= '0;
        words_written <= '0;
      end
      if (take_byte) begin
        icb_cmd_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
        byte_idx <= byte_idx + 3'd1;
        if (byte_idx == 3'd7) icb_cmd_addr <= BASE_ADDR + AW'({word_idx, 3'b000});
      end
      // Abort seen while a command is in flight is remembered until its response drains.
      if ((state == CMD || state == RSP) && load_abort) abort_q <= 1'b1;
      if (rsp_ok) begin
        word_idx      <= word_idx + CW'(1);
        words_written <= words_written + CW'(1);
      end
    end
  end

endmodule

// File: doc/e203_itcm_loader.md
Name: e203_itcm_loader

Overview:
- Synthesizable boot-image loader that sits directly upstream of the ITCM on the Genesys2 build.
- Takes a little-endian byte stream from a host link (UART/JTAG bridge) and packs each 8 bytes into one 64-bit ITCM line.
- Writes each line over a single-outstanding ICB write port into the ITCM.
- Holds the core in reset until the image is complete, replacing the simulation-only backdoor preload with a hardware path.

Parameters:
- AW, 16, ICB byte-address width.
- BASE_ADDR, 16'h0000, byte offset of word 0 inside ITCM; must be 8-byte aligned.
- MAX_WORDS, 8192, ITCM depth in 64-bit lines; equals E203_ITCM_RAM_DP.
- CW, 14, word-counter width; must satisfy 2**CW > MAX_WORDS.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; accepted only in IDLE, DONE or ERR.
- load_len  in  CW  number of 64-bit words to load; sampled on an accepted load_start.
- load_abort  in  1  level; requests abort of the current load.
- byte_valid  in  1  stream byte valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  stream byte accepted when byte_valid & byte_ready.
- icb_cmd_valid  out  1  ICB command valid.
- icb_cmd_ready  in  1  ICB command ready.
- icb_cmd_addr  out  AW  write byte address.
- icb_cmd_read  out  1  tied 0.
- icb_cmd_wdata  out  64  packed line.
- icb_cmd_wmask  out  8  tied 8'hFF.
- icb_rsp_valid  in  1  ICB response valid.
- icb_rsp_ready  out  1  tied 1.
- icb_rsp_err  in  1  ICB response error.
- core_hold  out  1  active-high hold of the core reset.
- load_done  out  1  level; image loaded successfully.
- load_err  out  1  level; load failed.
- words_written  out  CW  count of words acknowledged without error.

Behaviour:
- Reset values:
  - State IDLE; byte_ready=0, icb_cmd_valid=0, addr/wdata=0.
  - core_hold=1, load_done=0, load_err=0, words_written=0.
  - Byte index and word index both 0.
- States: IDLE, COLLECT, CMD, RSP, DONE, ERR.
- IDLE / DONE / ERR, on load_start:
  - load_len=0 goes to DONE; load_done=1, core_hold=0.
  - load_len>MAX_WORDS goes to ERR.
  - Otherwise latch len, clear indices, words_written, load_done and load_err; core_hold=1; go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - Accepted byte k (0..7) is written to wdata[8k+7:8k].
  - On k=7 accept: go to CMD next cycle; byte_ready=0 from that cycle on.
  - No bytes are accepted outside COLLECT.
- CMD:
  - icb_cmd_valid=1, icb_cmd_addr=BASE_ADDR+word_idx*8.
  - Addr, wdata and valid are held stable until icb_cmd_ready; valid never drops before acceptance.
  - On handshake go to RSP.
- RSP:
  - Wait for icb_rsp_valid. A same-cycle response in the cmd handshake cycle is not allowed; the ICB protocol guarantees a response arrives at least 1 cycle after the command.
  - rsp_err=1 goes to ERR.
  - Otherwise words_written+1 and word_idx+1. If word_idx+1==len go to DONE; else go to COLLECT.
- DONE: load_done=1, core_hold=0.
- ERR: load_err=1, core_hold=1; words_written is frozen.
- load_abort:
  - In COLLECT or CMD before the handshake: go to ERR next cycle; partial bytes are discarded.
  - In RSP: finish consuming the response first, then go to ERR.
  - In IDLE, DONE or ERR: no effect.
- load_start outside IDLE/DONE/ERR is ignored.
- load_start in DONE re-asserts core_hold=1 on the next cycle. A reload is a full restart of the image.
- Address arithmetic is AW bits; it cannot wrap because len ≤ MAX_WORDS is enforced.
- Asynchronous reset mid-load returns immediately to reset values. The ITCM contents are undefined.

Test Plan:
- Start, len=2, stream bytes 0x00..0x0F with byte_valid held high, icb_cmd_ready=1, response 1 cycle later -> two writes: addr 0x0000 wdata 64'h0706050403020100, addr 0x0008 wdata 64'h0F0E0D0C0B0A0908. Then load_done=1, core_hold=0, words_written=2.
- Same as above with icb_cmd_ready low for 5 cycles -> addr/wdata/valid are stable over all 5 cycles and byte_ready=0 throughout; exactly one write per word.
- len=3, icb_rsp_err=1 on word 1 -> load_err=1, core_hold=1, words_written=1; no write to addr 0x0010.
- load_abort after 3 bytes of word 0 -> ERR next cycle, no ICB command issued. A following start with len=1 and 8 bytes of 0xAA writes 64'hAAAAAAAAAAAAAAAA at 0x0000 and reaches DONE.
- len=0 -> DONE in 1 cycle with no ICB activity. len=MAX_WORDS+1 -> ERR with no activity.
- Assert rst_n=0 in RSP of word 4 -> all outputs return to reset values asynchronously, including core_hold=1 and words_written=0.
